// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - decoder/multiplier handshake bundle for the CPU cycle sequencer
interface cpu_sequencer_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 run;
  logic                 step_mode;
  logic                 sm_extra;
  logic                 stop;
  logic                 mul_start;
  logic                 mul_done;
  logic [1:0]           state;
  logic                 halted;
  logic                 mul_wait;
  logic [CNT_WIDTH-1:0] instr_retired;
  logic                 mul_timeout;

  // master is the sequencer itself; slave is the decoder/multiplier/control side
  modport master (
    input  run, step_mode, sm_extra, stop, mul_start, mul_done,
    output state, halted, mul_wait, instr_retired, mul_timeout
  );

  modport slave (
    output run, step_mode, sm_extra, stop, mul_start, mul_done,
    input  state, halted, mul_wait, instr_retired, mul_timeout
  );
endinterface

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - FETCH/EXEC1/EXEC2 cycle sequencer with multiply wait, halt/run/step and retire count
module cpu_sequencer #(
  parameter int MUL_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  cpu_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    S_HALT,
    S_FETCH,
    S_EXEC1,
    S_EXEC2,
    S_MUL_WAIT
  } seq_state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MUL_TIMEOUT - 1);

  seq_state_t           cur_q;
  logic [3:0]           outs_q;
  logic [7:0]           wait_cnt_q;
  logic [CNT_WIDTH-1:0] retired_q;
  logic                 timeout_q;

  // outs = {decoder state code, halted, mul_wait}; both idle states show 11 so the decoder stays quiet
  function automatic logic [3:0] enc(input seq_state_t s);
    case (s)
      S_FETCH:    enc = 4'b00_0_0;
      S_EXEC1:    enc = 4'b10_0_0;
      S_EXEC2:    enc = 4'b01_0_0;
      S_MUL_WAIT: enc = 4'b11_0_1;
      default:    enc = 4'b11_1_0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_q      <= S_HALT;
      outs_q     <= enc(S_HALT);
      wait_cnt_q <= 8'd0;
      retired_q  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      case (cur_q)
        S_HALT: begin
          if (bus.run) begin
            cur_q     <= S_FETCH;
            outs_q    <= enc(S_FETCH);
            timeout_q <= 1'b0;
          end
        end
        S_FETCH: begin
          cur_q  <= S_EXEC1;
          outs_q <= enc(S_EXEC1);
        end
        S_EXEC1: begin
          if (bus.stop) begin
            cur_q  <= S_HALT;
            outs_q <= enc(S_HALT);
          end else if (bus.mul_start) begin
            cur_q      <= S_MUL_WAIT;
            outs_q     <= enc(S_MUL_WAIT);
            wait_cnt_q <= 8'd0;
          end else if (bus.sm_extra) begin
            cur_q  <= S_EXEC2;
            outs_q <= enc(S_EXEC2);
          end else begin
            cur_q     <= bus.step_mode ? S_HALT : S_FETCH;
            outs_q    <= enc(bus.step_mode ? S_HALT : S_FETCH);
            retired_q <= retired_q + CNT_WIDTH'(1);
          end
        end
        S_EXEC2: begin
          cur_q     <= bus.step_mode ? S_HALT : S_FETCH;
          outs_q    <= enc(bus.step_mode ? S_HALT : S_FETCH);
          retired_q <= retired_q + CNT_WIDTH'(1);
        end
        S_MUL_WAIT: begin
          // a result arriving on the last allowed cycle still retires
          if (bus.mul_done) begin
            cur_q     <= bus.step_mode ? S_HALT : S_FETCH;
            outs_q    <= enc(bus.step_mode ? S_HALT : S_FETCH);
            retired_q <= retired_q + CNT_WIDTH'(1);
          end else if (wait_cnt_q == TIMEOUT_LAST) begin
            cur_q     <= S_HALT;
            outs_q    <= enc(S_HALT);
            timeout_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        default: begin
          cur_q  <= S_HALT;
          outs_q <= enc(S_HALT);
        end
      endcase
    end
  end

  assign bus.state         = outs_q[3:2];
  assign bus.halted        = outs_q[1];
  assign bus.mul_wait      = outs_q[0];
  assign bus.instr_retired = retired_q;
  assign bus.mul_timeout   = timeout_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - randomized instruction-level bench for cpu_sequencer
module tb_cpu_sequencer;

  localparam int MT = 16;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  cpu_sequencer_if #(.CNT_WIDTH(CW)) bus ();

  cpu_sequencer #(.MUL_TIMEOUT(MT), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference model: instruction count (mod 2^CW), sticky timeout flag, whether the CPU is parked
  int exp_cnt = 0;
  bit exp_to = 1'b0;
  bit exp_halt = 1'b0;

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // check the visible outputs for this cycle, then drive this cycle's inputs and advance one clock
  task automatic cyc(input logic [1:0] es, input logic eh, input logic em,
                     input logic r, input logic s, input logic x,
                     input logic p, input logic m, input logic d);
    chk("state",         32'(bus.state),         32'(es));
    chk("halted",        32'(bus.halted),        32'(eh));
    chk("mul_wait",      32'(bus.mul_wait),      32'(em));
    chk("instr_retired", 32'(bus.instr_retired), 32'(exp_cnt % (1 << CW)));
    chk("mul_timeout",   32'(bus.mul_timeout),   32'(exp_to));
    bus.run = r; bus.step_mode = s; bus.sm_extra = x;
    bus.stop = p; bus.mul_start = m; bus.mul_done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input bit stepm);
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    exp_halt = stepm;
  endtask

  // sit in HALT a few cycles with stray inputs, then pulse run
  task automatic resume();
    int n;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++)
      cyc(2'b11, 1'b1, 1'b0, 1'b0, rb(), rb(), rb(), rb(), rb());
    cyc(2'b11, 1'b1, 1'b0, 1'b1, rb(), rb(), rb(), rb(), rb());
    exp_to = 1'b0;
    exp_halt = 1'b0;
  endtask

  // kind: 0 plain, 1 needs EXEC2, 2 multiply done on wait cycle k, 3 multiply timeout, 4 stop
  task automatic instr(input int kind, input int k, input bit stepm);
    cyc(2'b00, 1'b0, 1'b0, rb(), rb(), rb(), rb(), rb(), rb());
    case (kind)
      0: begin
        cyc(2'b10, 1'b0, 1'b0, rb(), stepm, 1'b0, 1'b0, 1'b0, rb());
        retire(stepm);
      end
      1: begin
        cyc(2'b10, 1'b0, 1'b0, rb(), rb(), 1'b1, 1'b0, 1'b0, rb());
        cyc(2'b01, 1'b0, 1'b0, rb(), stepm, rb(), rb(), rb(), rb());
        retire(stepm);
      end
      2: begin
        cyc(2'b10, 1'b0, 1'b0, rb(), rb(), rb(), 1'b0, 1'b1, rb());
        for (int i = 1; i <= k; i++)
          cyc(2'b11, 1'b0, 1'b1, rb(), (i == k) ? logic'(stepm) : rb(), rb(), rb(), rb(), logic'(i == k));
        retire(stepm);
      end
      3: begin
        cyc(2'b10, 1'b0, 1'b0, rb(), rb(), rb(), 1'b0, 1'b1, rb());
        for (int i = 1; i <= MT; i++)
          cyc(2'b11, 1'b0, 1'b1, rb(), rb(), rb(), rb(), rb(), 1'b0);
        exp_to = 1'b1;
        exp_halt = 1'b1;
      end
      default: begin
        cyc(2'b10, 1'b0, 1'b0, rb(), rb(), rb(), 1'b1, rb(), rb());
        exp_halt = 1'b1;
      end
    endcase
    if (exp_halt) resume();
  endtask

  initial begin
    bus.run = 1'b0; bus.step_mode = 1'b0; bus.sm_extra = 1'b0;
    bus.stop = 1'b0; bus.mul_start = 1'b0; bus.mul_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc(2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) instr(0, 0, 1'b0);
    instr(1, 0, 1'b0);
    instr(2, 4, 1'b0);
    instr(3, 0, 1'b0);
    instr(4, 0, 1'b0);
    instr(0, 0, 1'b1);
    instr(2, MT, 1'b0);
    instr(2, 1, 1'b1);
    for (int i = 0; i < 18; i++) instr(0, 0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind > 4) kind = kind - 5;
      instr(kind, $urandom_range(1, MT), bit'($urandom_range(0, 3) == 0));
    end

    // abort an instruction in EXEC2 with reset
    instr(0, 0, 1'b0);
    cyc(2'b00, 1'b0, 1'b0, rb(), rb(), rb(), rb(), rb(), rb());
    cyc(2'b10, 1'b0, 1'b0, rb(), 1'b0, 1'b1, 1'b0, 1'b0, rb());
    rst_n = 1'b0;
    cyc(2'b01, 1'b0, 1'b0, rb(), 1'b0, rb(), rb(), rb(), rb());
    exp_cnt = 0;
    exp_to = 1'b0;
    rst_n = 1'b1;
    cyc(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    instr(1, 0, 1'b0);
    cyc(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
